game_ctrl: RTL and testbench

Game sequencer for the PACMAN design. Runs the round state machine (idle, ready countdown, play, dying, win, game over), schedules PACMAN and ghost movement steps from the VGA frame tick, detects PACMAN–ghost collision, and keeps lives and score. Sits between the input path (keypad/PS2 start request), the movers (PACMAN controller, ghosts) and the display/7-segment outputs; its 2-bit `state` drives the display mode.

---
 rtl/game_pkg.sv | 35 +++
 rtl/tick_divider.sv | 50 +++++
 rtl/game_ctrl.sv | 174 +++++++++++++++++
 tb/tb_game_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types for the PACMAN game sequencer: round FSM states, the display
// state codes and the 10-bit screen coordinate type.
package game_pkg;

  typedef enum logic [2:0] {
    FSM_IDLE  = 3'd0,
    FSM_READY = 3'd1,
    FSM_PLAY  = 3'd2,
    FSM_DYING = 3'd3,
    FSM_WIN   = 3'd4,
    FSM_OVER  = 3'd5
  } fsm_e;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_WIN  = 2'b10;
  localparam logic [1:0] ST_OVER = 2'b11;

  typedef logic [9:0] coord_t;

  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // READY shares the IDLE display code and DYING shares the PLAY code.
  function automatic logic [1:0] state_code(input fsm_e s);
    case (s)
      FSM_PLAY, FSM_DYING: return ST_PLAY;
      FSM_WIN:             return ST_WIN;
      FSM_OVER:            return ST_OVER;
      default:             return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Frame-tick divider: emits a one-cycle pulse every `limit` advancing ticks.
// The limit is captured on clear and at each wrap, so a change lands at the next wrap.
module tick_divider #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic [W-1:0] limit,
  input  logic         clear,
  input  logic         frame_tick,
  output logic         pulse
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] lim_q, lim_d;
  logic         pulse_q, pulse_d;

  always_comb begin
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    pulse_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
      lim_d = limit;
    end else if (frame_tick) begin
      if (cnt_q == lim_q - W'(1)) begin
        cnt_d   = '0;
        lim_d   = limit;
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q   <= '0;
      lim_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// PACMAN round sequencer: round FSM, move-step scheduling, collision, lives and score.
// Optional macro GAME_CTRL_SPEEDUP_EN halves the ghost step period while fewer than 64 dots remain.
module game_ctrl
  import game_pkg::*;
#(
  parameter int PAC_DIV      = 4,
  parameter int GHOST_DIV    = 5,
  parameter int READY_FRAMES = 120,
  parameter int DYING_FRAMES = 60,
  parameter int HIT_DIST     = 16,
  parameter int LIVES        = 3,
  parameter int DOT_POINTS   = 10
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [9:0]  pac_x,
  input  logic [9:0]  pac_y,
  input  logic [9:0]  ghost_x,
  input  logic [8:0]  ghost_y,
  input  logic        dot_eaten,
  input  logic [7:0]  dots_left,
  output logic [1:0]  state,
  output logic        pac_move_en,
  output logic        ghost_move_en,
  output logic        respawn,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic        result,
  output logic [2:0]  dbg_fsm
);

  localparam int FRM_MAX = (READY_FRAMES > DYING_FRAMES) ? READY_FRAMES : DYING_FRAMES;
  localparam int FRM_W   = $clog2(FRM_MAX + 1);
  localparam int DIV_MAX = (PAC_DIV > GHOST_DIV) ? PAC_DIV : GHOST_DIV;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);

  localparam logic [FRM_W-1:0] READY_LAST = FRM_W'(READY_FRAMES - 1);
  localparam logic [FRM_W-1:0] DYING_LAST = FRM_W'(DYING_FRAMES - 1);
  localparam logic [DIV_W-1:0] PAC_LIM    = DIV_W'(PAC_DIV);

  fsm_e              fsm_q, fsm_d;
  logic              start_q;
  logic [FRM_W-1:0]  frm_q, frm_d;
  logic [1:0]        lives_q, lives_d;
  logic [15:0]       score_q, score_d;
  logic              result_q, result_d;
  logic [1:0]        state_q, state_d;
  logic              respawn_q, respawn_d;

  logic              start_rise;
  logic              hit;
  logic              play_step;
  logic              enter_ready;
  logic              new_game;
  logic [16:0]       score_sum;
  logic [DIV_W-1:0]  ghost_limit;
  coord_t            dx, dy;

  assign start_rise = start & ~start_q;
  assign dx         = abs_diff(pac_x, ghost_x);
  assign dy         = abs_diff(pac_y, coord_t'({1'b0, ghost_y}));
  assign hit        = (int'(dx) < HIT_DIST) && (int'(dy) < HIT_DIST);
  assign score_sum  = {1'b0, score_q} + 17'(DOT_POINTS);

  // Dividers only advance on PLAY ticks that neither win nor kill.
  assign play_step   = (fsm_q == FSM_PLAY) && frame_tick && (dots_left != 8'd0) && !hit;
  assign enter_ready = (fsm_d == FSM_READY) && (fsm_q != FSM_READY);
  assign new_game    = enter_ready && (fsm_q != FSM_DYING);

`ifdef GAME_CTRL_SPEEDUP_EN
  localparam int GHOST_FAST = (GHOST_DIV / 2 >= 1) ? GHOST_DIV / 2 : 1;
  assign ghost_limit = (dots_left < 8'd64) ? DIV_W'(GHOST_FAST) : DIV_W'(GHOST_DIV);
`else
  assign ghost_limit = DIV_W'(GHOST_DIV);
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) fsm_q <= FSM_IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      FSM_IDLE, FSM_WIN, FSM_OVER: if (start_rise) fsm_d = FSM_READY;
      FSM_READY: if (frame_tick && frm_q == READY_LAST) fsm_d = FSM_PLAY;
      FSM_PLAY: begin
        if (frame_tick) begin
          if (dots_left == 8'd0) fsm_d = FSM_WIN;
          else if (hit)          fsm_d = FSM_DYING;
        end
      end
      FSM_DYING: begin
        if (frame_tick && frm_q == DYING_LAST)
          fsm_d = (lives_q == 2'd0) ? FSM_OVER : FSM_READY;
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  always_comb begin
    frm_d     = frm_q;
    lives_d   = lives_q;
    score_d   = score_q;
    result_d  = result_q;
    state_d   = state_code(fsm_d);
    respawn_d = enter_ready;

    if (fsm_d != fsm_q)
      frm_d = '0;
    else if (frame_tick && (fsm_q == FSM_READY || fsm_q == FSM_DYING))
      frm_d = frm_q + FRM_W'(1);

    if (new_game) begin
      lives_d  = 2'(LIVES);
      score_d  = 16'd0;
      result_d = 1'b0;
    end else begin
      if (fsm_q == FSM_PLAY && fsm_d == FSM_DYING) lives_d = lives_q - 2'd1;
      if (fsm_q == FSM_PLAY && dot_eaten)
        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      if (fsm_q == FSM_PLAY && fsm_d == FSM_WIN)   result_d = 1'b1;
      if (fsm_q == FSM_DYING && fsm_d == FSM_OVER) result_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      start_q   <= 1'b0;
      frm_q     <= '0;
      lives_q   <= 2'd0;
      score_q   <= 16'd0;
      result_q  <= 1'b0;
      state_q   <= ST_IDLE;
      respawn_q <= 1'b0;
    end else begin
      start_q   <= start;
      frm_q     <= frm_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      result_q  <= result_d;
      state_q   <= state_d;
      respawn_q <= respawn_d;
    end
  end

  tick_divider #(.W(DIV_W)) u_pac_div (
    .clk        (clk),
    .clrn       (clrn),
    .limit      (PAC_LIM),
    .clear      (enter_ready),
    .frame_tick (play_step),
    .pulse      (pac_move_en)
  );

  tick_divider #(.W(DIV_W)) u_ghost_div (
    .clk        (clk),
    .clrn       (clrn),
    .limit      (ghost_limit),
    .clear      (enter_ready),
    .frame_tick (play_step),
    .pulse      (ghost_move_en)
  );

  assign state   = state_q;
  assign lives   = lives_q;
  assign score   = score_q;
  assign result  = result_q;
  assign respawn = respawn_q;
  assign dbg_fsm = fsm_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized bench for game_ctrl: a round-level reference model predicts every
// cycle's outputs into a queue that a negedge monitor pops and compares.
module tb_game_ctrl;

  localparam int P_PAC   = 4;
  localparam int P_GHOST = 5;
  localparam int P_READY = 120;
  localparam int P_DYING = 60;
  localparam int P_HIT   = 16;
  localparam int P_LIVES = 3;
  localparam int P_DOT   = 10;

  localparam int PH_IDLE  = 0;
  localparam int PH_READY = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_DYING = 3;
  localparam int PH_WIN   = 4;
  localparam int PH_OVER  = 5;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  pac_x = '0;
  logic [9:0]  pac_y = '0;
  logic [9:0]  ghost_x = '0;
  logic [8:0]  ghost_y = '0;
  logic        dot_eaten = 1'b0;
  logic [7:0]  dots_left = 8'd100;
  logic [1:0]  state;
  logic        pac_move_en, ghost_move_en, respawn;
  logic [1:0]  lives;
  logic [15:0] score;
  logic        result;
  logic [2:0]  dbg_fsm;

  int n_checks = 0;
  int n_fail   = 0;
  int pac_cnt  = 0;
  int ghost_cnt = 0;

  logic [23:0] exp_q[$];

  // Reference model state.
  int m_phase = PH_IDLE;
  int m_frames, m_pac, m_ghost, m_glim, m_lives, m_score;
  bit m_result, m_prev_start;

  always #5 clk = ~clk;

  game_ctrl dut (
    .clk           (clk),
    .clrn          (clrn),
    .frame_tick    (frame_tick),
    .start         (start),
    .pac_x         (pac_x),
    .pac_y         (pac_y),
    .ghost_x       (ghost_x),
    .ghost_y       (ghost_y),
    .dot_eaten     (dot_eaten),
    .dots_left     (dots_left),
    .state         (state),
    .pac_move_en   (pac_move_en),
    .ghost_move_en (ghost_move_en),
    .respawn       (respawn),
    .lives         (lives),
    .score         (score),
    .result        (result),
    .dbg_fsm       (dbg_fsm)
  );

  function automatic int ghost_limit_now(input int dl);
`ifdef GAME_CTRL_SPEEDUP_EN
    if (dl < 64) return (P_GHOST / 2 >= 1) ? P_GHOST / 2 : 1;
`endif
    return P_GHOST;
  endfunction

  function automatic logic [1:0] disp_code(input int ph);
    if (ph == PH_PLAY || ph == PH_DYING) return 2'b01;
    if (ph == PH_WIN)  return 2'b10;
    if (ph == PH_OVER) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_frames = 0; m_pac = 0; m_ghost = 0; m_glim = 0;
    m_lives = 0; m_score = 0; m_result = 0; m_prev_start = 0;
  endtask

  task automatic model_step();
    bit rise, hit, pp, gp, rs;
    int dx, dy;
    if (!clrn) begin
      model_reset();
      exp_q.push_back(24'h0);
      return;
    end
    pp = 0; gp = 0; rs = 0;
    rise = start && !m_prev_start;
    m_prev_start = start;
    dx = int'(pac_x) - int'(ghost_x);
    dy = int'(pac_y) - int'(ghost_y);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    hit = (dx < P_HIT) && (dy < P_HIT);
    if (dot_eaten && m_phase == PH_PLAY)
      m_score = (m_score + P_DOT > 65535) ? 65535 : m_score + P_DOT;
    case (m_phase)
      PH_IDLE, PH_WIN, PH_OVER: begin
        if (rise) begin
          m_lives = P_LIVES; m_score = 0; m_result = 0;
          m_phase = PH_READY; m_frames = 0; m_pac = 0; m_ghost = 0;
          m_glim = ghost_limit_now(int'(dots_left)); rs = 1;
        end
      end
      PH_READY: begin
        if (frame_tick) begin
          m_frames++;
          if (m_frames == P_READY) begin m_phase = PH_PLAY; m_frames = 0; end
        end
      end
      PH_PLAY: begin
        if (frame_tick) begin
          if (dots_left == 0) begin
            m_phase = PH_WIN; m_result = 1;
          end else if (hit) begin
            m_phase = PH_DYING; m_lives--; m_frames = 0;
          end else begin
            m_pac++;
            if (m_pac == P_PAC) begin pp = 1; m_pac = 0; end
            m_ghost++;
            if (m_ghost == m_glim) begin
              gp = 1; m_ghost = 0; m_glim = ghost_limit_now(int'(dots_left));
            end
          end
        end
      end
      default: begin
        if (frame_tick) begin
          m_frames++;
          if (m_frames == P_DYING) begin
            m_frames = 0;
            if (m_lives == 0) begin
              m_phase = PH_OVER; m_result = 0;
            end else begin
              m_phase = PH_READY; m_pac = 0; m_ghost = 0;
              m_glim = ghost_limit_now(int'(dots_left)); rs = 1;
            end
          end
        end
      end
    endcase
    exp_q.push_back({disp_code(m_phase), 2'(m_lives), 16'(m_score), m_result, pp, gp, rs});
  endtask

  // Clock/reset block: model at posedge, async reset overrides pending expectation.
  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clrn);
    exp_q.delete();
    exp_q.push_back(24'h0);
  end

  // Monitor / scoreboard.
  initial forever begin
    logic [23:0] e, g;
    @(negedge clk);
    g = {state, lives, score, result, pac_move_en, ghost_move_en, respawn};
    if (pac_move_en) pac_cnt++;
    if (ghost_move_en) ghost_cnt++;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_underflow t=%0t got=%h", $time, g);
    end else begin
      e = exp_q.pop_front();
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got st=%b lv=%0d sc=%h res=%b pac=%b gh=%b rsp=%b exp st=%b lv=%0d sc=%h res=%b pac=%b gh=%b rsp=%b",
                 $time, g[23:22], g[21:20], g[19:4], g[3], g[2], g[1], g[0],
                 e[23:22], e[21:20], e[19:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Driver tasks.
  task automatic step(input bit tick, input bit dot);
    frame_tick = tick;
    dot_eaten  = dot;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    dot_eaten  = 1'b0;
  endtask

  task automatic frames(input int n, input int dot_pct);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) step(1'b0, $urandom_range(0, 99) < dot_pct);
      step(1'b1, $urandom_range(0, 99) < dot_pct);
    end
  endtask

  task automatic set_far();
    pac_x     = 10'($urandom_range(0, 400));
    pac_y     = 10'($urandom_range(0, 1023));
    ghost_x   = 10'($urandom_range(600, 1023));
    ghost_y   = 9'($urandom_range(0, 511));
    dots_left = 8'($urandom_range(64, 255));
  endtask

  task automatic set_hit();
    pac_x = 10'd100; pac_y = 10'd100; ghost_x = 10'd110; ghost_y = 9'd105;
  endtask

  task automatic set_near();
    int px, py, gx, gy;
    px = $urandom_range(30, 990);
    py = $urandom_range(30, 480);
    gx = px + int'($urandom_range(0, 40)) - 20;
    gy = py + int'($urandom_range(0, 40)) - 20;
    pac_x = 10'(px); pac_y = 10'(py); ghost_x = 10'(gx); ghost_y = 9'(gy);
    dots_left = 8'($urandom_range(1, 255));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    set_far();
    repeat (3) @(posedge clk);
    #1;
    clrn = 1'b1;
    step(0, 0); step(0, 0);
    check("reset_state", int'(state), 0);
    check("reset_lives", int'(lives), 0);
    check("reset_score", int'(score), 0);

    start = 1'b1;
    step(0, 0);
    check("start_respawn", int'(respawn), 1);
    check("start_lives", int'(lives), 3);
    check("start_state", int'(state), 0);
    frames(P_READY - 1, 30);
    check("ready_hold_state", int'(state), 0);
    check("ready_dot_ignored", int'(score), 0);
    frames(1, 30);
    check("play_state", int'(state), 1);

    step(0, 1); step(0, 1); step(0, 1);
    check("three_dots", int'(score), 30);

    pac_cnt = 0; ghost_cnt = 0;
    frames(20, 0);
    step(0, 0);
    check("pac_pulses_20", pac_cnt, 5);
    check("ghost_pulses_20", ghost_cnt, 4);
    frames(10, 40);

    for (int d = 0; d < 3; d++) begin
      if (d == 0) begin
        int guard = 0;
        while (m_phase == PH_PLAY && guard < 400) begin
          set_near();
          step(1, $urandom_range(0, 1));
          guard++;
        end
        check("near_loop_left_play", int'(m_phase == PH_PLAY), 0);
      end else begin
        set_hit();
        step(1, 1);
      end
      check("death_lives", int'(lives), 2 - d);
      check("dying_state", int'(state), 1);
      set_far();
      frames(P_DYING - 1, 20);
      check("dying_hold", int'(state), 1);
      frames(1, 0);
      if (d < 2) begin
        check("respawn_after_dying", int'(respawn), 1);
        check("ready_after_dying", int'(state), 0);
        frames(P_READY, 20);
        check("replay_state", int'(state), 1);
      end else begin
        check("over_state", int'(state), 3);
        check("over_result", int'(result), 0);
      end
    end

    repeat (5) step(0, 0);
    check("held_start_no_restart", int'(state), 3);
    start = 1'b0; step(0, 0);
    start = 1'b1; step(0, 0);
    check("restart_state", int'(state), 0);
    check("restart_lives", int'(lives), 3);
    check("restart_respawn", int'(respawn), 1);
    frames(P_READY, 10);
    check("game2_play", int'(state), 1);

    repeat (6553) step(0, 1);
    check("score_fffa", int'(score), 16'hFFFA);
    step(0, 1);
    check("score_sat", int'(score), 16'hFFFF);
    step(0, 1);
    check("score_sat_hold", int'(score), 16'hFFFF);

    set_hit();
    dots_left = 8'd0;
    step(1, 0);
    check("win_state", int'(state), 2);
    check("win_result", int'(result), 1);
    check("win_lives", int'(lives), 3);
    frames(3, 20);
    check("win_hold", int'(state), 2);

    set_far();
    start = 1'b0; step(0, 0);
    start = 1'b1; step(0, 0);
    check("game3_lives", int'(lives), 3);
    frames(P_READY, 20);
    frames(5, 30);
    check("game3_play", int'(state), 1);
    start = 1'b0;
    step(0, 0);
    clrn = 1'b0;
    #1;
    check("async_state", int'(state), 0);
    check("async_lives", int'(lives), 0);
    check("async_score", int'(score), 0);
    check("async_pulses", int'({pac_move_en, ghost_move_en, respawn}), 0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    repeat (4) step(0, 0);
    check("post_reset_state", int'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
